// File: rtl/lcd_pkg.sv
// lcd_pkg: shared FSM states, transfer phases and timing
// defaults for the HD44780 bus sequencer.
package lcd_pkg;

  localparam int DEF_SETUP_CYC   = 2;
  localparam int DEF_E_HIGH_CYC  = 12;
  localparam int DEF_HOLD_CYC    = 2;
  localparam int DEF_POLL_BUSY   = 1;
  localparam int DEF_TIMEOUT_CYC = 100000;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    E_HIGH,
    HOLD,
    P_SETUP,
    P_E_HIGH,
    P_HOLD
  } lcd_state_t;

  typedef enum logic [1:0] {
    PH_IDLE,
    PH_SETUP,
    PH_E_HIGH,
    PH_HOLD
  } xfer_phase_t;

  // A cycle count of zero behaves as one.
  function automatic int cyc_eff(input int v);
    return (v < 1) ? 1 : v;
  endfunction

  function automatic int cyc_max3(
    input int a,
    input int b,
    input int c
  );
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/lcd_xfer_timer.sv
// lcd_xfer_timer: pin-timing engine for one HD44780 bus transfer.
// Ports: clk/reset; phase (from owner FSM); load + ld_* fields;
// publish (expose read byte); last/done phase-end flags; bf
// (sampled bit 7); rd_valid/rd_data; LCD pins lcd_e/rs/rw/data.
module lcd_xfer_timer
  import lcd_pkg::*;
#(
  parameter int SETUP_CYC  = DEF_SETUP_CYC,
  parameter int E_HIGH_CYC = DEF_E_HIGH_CYC,
  parameter int HOLD_CYC   = DEF_HOLD_CYC
) (
  input  logic        clk,
  input  logic        reset,
  input  xfer_phase_t phase,
  input  logic        load,
  input  logic        ld_rs,
  input  logic        ld_rw,
  input  logic [7:0]  ld_data,
  input  logic        publish,
  output logic        last,
  output logic        done,
  output logic        bf,
  output logic        rd_valid,
  output logic [7:0]  rd_data,
  output logic        lcd_e,
  output logic        lcd_rs,
  output logic        lcd_rw,
  inout  wire  [7:0]  lcd_data
);

  localparam int S_N = cyc_eff(SETUP_CYC);
  localparam int E_N = cyc_eff(E_HIGH_CYC);
  localparam int H_N = cyc_eff(HOLD_CYC);
  localparam int CW  = $clog2(cyc_max3(S_N, E_N, H_N) + 1);

  localparam logic [CW-1:0] S_LAST = CW'(S_N - 1);
  localparam logic [CW-1:0] E_LAST = CW'(E_N - 1);
  localparam logic [CW-1:0] H_LAST = CW'(H_N - 1);

  logic [CW-1:0] cnt;
  logic          rs_q;
  logic          rw_q;
  logic [7:0]    wd_q;
  logic          active;
  logic          smp;

  assign active = (phase != PH_IDLE);

  always_comb begin
    last = 1'b0;
    unique case (phase)
      PH_SETUP:  last = (cnt == S_LAST);
      PH_E_HIGH: last = (cnt == E_LAST);
      PH_HOLD:   last = (cnt == H_LAST);
      default:   last = 1'b0;
    endcase
  end

  assign done = (phase == PH_HOLD) && last;

  // Bus is sampled on the final E-high cycle of a read.
  assign smp = (phase == PH_E_HIGH) && last && rw_q;

  // Counter restarts at every phase boundary.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (!active || last) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rs_q <= 1'b0;
      rw_q <= 1'b1;
      wd_q <= 8'h00;
    end else if (load) begin
      rs_q <= ld_rs;
      rw_q <= ld_rw;
      wd_q <= ld_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_valid <= 1'b0;
      rd_data  <= 8'h00;
      bf       <= 1'b0;
    end else begin
      rd_valid <= smp && publish;
      if (smp) bf <= lcd_data[7];
      if (smp && publish) rd_data <= lcd_data;
    end
  end

  // Pins fall back to the idle pattern as soon as the
  // owner leaves a transfer, including on async reset.
  assign lcd_e  = (phase == PH_E_HIGH);
  assign lcd_rs = active && rs_q;
  assign lcd_rw = !active || rw_q;

  assign lcd_data = (active && !rw_q) ? wd_q : 8'hzz;

endmodule

// File: rtl/lcd_bus_sequencer.sv
// lcd_bus_sequencer: HD44780 command sequencer with busy polling.
// Ports: clk, reset; cmd_valid/cmd_ready + cmd_rs/rw/data; rd_valid,
// rd_data; busy_timeout (sticky); LCD_E/RS/RW/data pins.
module lcd_bus_sequencer
  import lcd_pkg::*;
#(
  parameter int SETUP_CYC   = DEF_SETUP_CYC,
  parameter int E_HIGH_CYC  = DEF_E_HIGH_CYC,
  parameter int HOLD_CYC    = DEF_HOLD_CYC,
  parameter int POLL_BUSY   = DEF_POLL_BUSY,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_rs,
  input  logic       cmd_rw,
  input  logic [7:0] cmd_data,
  output logic       rd_valid,
  output logic [7:0] rd_data,
  output logic       busy_timeout,
  output logic       LCD_E,
  output logic       LCD_RS,
  output logic       LCD_RW,
  inout  wire  [7:0] LCD_data
);

  localparam int T_N = cyc_eff(TIMEOUT_CYC);
  localparam int TW  = $clog2(T_N + 1);

  localparam logic [TW-1:0] T_LAST = TW'(T_N - 1);

  lcd_state_t  state;
  lcd_state_t  nstate;
  xfer_phase_t phase;

  logic          up;
  logic          accept;
  logic          load;
  logic          ld_rs;
  logic          ld_rw;
  logic [7:0]    ld_data;
  logic          publish;
  logic          last;
  logic          done;
  logic          bf;
  logic          status_cmd;
  logic          poll_start;
  logic          in_poll;
  logic          tmo_seen;
  logic          tmo_now;
  logic [TW-1:0] tcnt;

  assign cmd_ready = up && (state == IDLE);
  assign accept    = cmd_valid && cmd_ready;
  assign publish   = (state == E_HIGH);

  // Pins still carry the command fields during HOLD.
  assign status_cmd = !LCD_RS && LCD_RW;

  assign in_poll = (state == P_SETUP)
                || (state == P_E_HIGH)
                || (state == P_HOLD);

  assign tmo_now = in_poll && !tmo_seen
                && (tcnt == T_LAST);

  lcd_xfer_timer #(
    .SETUP_CYC  (SETUP_CYC),
    .E_HIGH_CYC (E_HIGH_CYC),
    .HOLD_CYC   (HOLD_CYC)
  ) u_xfer (
    .clk      (clk),
    .reset    (reset),
    .phase    (phase),
    .load     (load),
    .ld_rs    (ld_rs),
    .ld_rw    (ld_rw),
    .ld_data  (ld_data),
    .publish  (publish),
    .last     (last),
    .done     (done),
    .bf       (bf),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .lcd_e    (LCD_E),
    .lcd_rs   (LCD_RS),
    .lcd_rw   (LCD_RW),
    .lcd_data (LCD_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= nstate;
    end
  end

  // Holds cmd_ready low until the first edge out of reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      up <= 1'b0;
    end else begin
      up <= 1'b1;
    end
  end

  always_comb begin
    nstate     = state;
    phase      = PH_IDLE;
    load       = 1'b0;
    ld_rs      = cmd_rs;
    ld_rw      = cmd_rw;
    ld_data    = cmd_data;
    poll_start = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          load   = 1'b1;
          nstate = SETUP;
        end
      end
      SETUP: begin
        phase = PH_SETUP;
        if (last) nstate = E_HIGH;
      end
      E_HIGH: begin
        phase = PH_E_HIGH;
        if (last) nstate = HOLD;
      end
      HOLD: begin
        phase = PH_HOLD;
        if (done) begin
          if ((POLL_BUSY != 0) && !status_cmd) begin
            nstate     = P_SETUP;
            poll_start = 1'b1;
            load       = 1'b1;
            ld_rs      = 1'b0;
            ld_rw      = 1'b1;
            ld_data    = 8'h00;
          end else begin
            nstate = IDLE;
          end
        end
      end
      P_SETUP: begin
        phase = PH_SETUP;
        if (last) nstate = P_E_HIGH;
      end
      P_E_HIGH: begin
        phase = PH_E_HIGH;
        if (last) nstate = P_HOLD;
      end
      P_HOLD: begin
        phase = PH_HOLD;
        if (done) begin
          if (tmo_now || tmo_seen || !bf) begin
            nstate = IDLE;
          end else begin
            nstate = P_SETUP;
          end
        end
      end
      default: nstate = IDLE;
    endcase
  end

  // Poll-loop length counter; stops once the limit is hit
  // so it can never wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tcnt     <= '0;
      tmo_seen <= 1'b0;
    end else if (poll_start) begin
      tcnt     <= '0;
      tmo_seen <= 1'b0;
    end else if (in_poll && !tmo_seen) begin
      if (tmo_now) begin
        tmo_seen <= 1'b1;
      end else begin
        tcnt <= tcnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_timeout <= 1'b0;
    end else if (tmo_now) begin
      busy_timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_lcd_bus_sequencer.sv
// tb_lcd_bus_sequencer: directed + random checks of the LCD sequencer
// against a cycle-offset model of the bus transfer.
module tb_lcd_bus_sequencer;

  localparam int S    = 2;
  localparam int EH   = 12;
  localparam int H    = 2;
  localparam int T    = 200;
  localparam int XFER = S + EH + H;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // instance 0: no polling
  logic       v0, rdy0, rs0, rw0, rdv0, bto0;
  logic       e0, lrs0, lrw0;
  logic [7:0] d0, rdd0, m0;
  wire  [7:0] bus0;
  logic [7:0] exp_rd0;

  assign bus0 = lrw0 ? m0 : 8'hzz;

  // instance 1: polling, short timeout
  logic       v1, rdy1, rs1, rw1, rdv1, bto1;
  logic       e1, lrs1, lrw1;
  logic [7:0] d1, rdd1, m1;
  wire  [7:0] bus1;
  logic [7:0] m1lo;
  int         busy1;
  int         base1;
  int         e_cnt1 = 0;
  logic       e1_d = 1'b0;
  int         n1;

  assign bus1 = lrw1 ? m1 : 8'hzz;

  // Display model: E pulse n (1 = the command itself)
  // reports busy for polls 1..busy1.
  always @(posedge clk) begin
    e1_d <= e1;
    if (e1 && !e1_d) e_cnt1 <= e_cnt1 + 1;
  end

  always_comb begin
    n1 = e_cnt1 - base1;
    m1 = {((n1 >= 2) && (n1 - 1 <= busy1)), m1lo[6:0]};
  end

  lcd_bus_sequencer #(
    .SETUP_CYC(S), .E_HIGH_CYC(EH), .HOLD_CYC(H),
    .POLL_BUSY(0), .TIMEOUT_CYC(T)
  ) u0 (
    .clk(clk), .reset(reset),
    .cmd_valid(v0), .cmd_ready(rdy0),
    .cmd_rs(rs0), .cmd_rw(rw0), .cmd_data(d0),
    .rd_valid(rdv0), .rd_data(rdd0),
    .busy_timeout(bto0),
    .LCD_E(e0), .LCD_RS(lrs0), .LCD_RW(lrw0),
    .LCD_data(bus0)
  );

  lcd_bus_sequencer #(
    .SETUP_CYC(S), .E_HIGH_CYC(EH), .HOLD_CYC(H),
    .POLL_BUSY(1), .TIMEOUT_CYC(T)
  ) u1 (
    .clk(clk), .reset(reset),
    .cmd_valid(v1), .cmd_ready(rdy1),
    .cmd_rs(rs1), .cmd_rw(rw1), .cmd_data(d1),
    .rd_valid(rdv1), .rd_data(rdd1),
    .busy_timeout(bto1),
    .LCD_E(e1), .LCD_RS(lrs1), .LCD_RW(lrw1),
    .LCD_data(bus1)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic wait_rdy(input int which, input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if ((which == 0) ? rdy0 : rdy1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk(tag, 32'(ok), 32'd1);
  endtask

  // Non-polling transfer: every pin checked against its
  // cycle offset t from the acceptance edge.
  task automatic run0(
    input logic       rs,
    input logic       rw,
    input logic [7:0] d,
    input bit         keep
  );
    bit inx;
    rs0 = rs; rw0 = rw; d0 = d; v0 = 1'b1;
    wait_rdy(0, "rdy_wait0");
    @(posedge clk);
    #1;
    if (!keep) v0 = 1'b0;
    for (int t = 1; t <= XFER + 1; t++) begin
      @(negedge clk);
      inx = (t <= XFER);
      if (rw && t == S + EH + 1) exp_rd0 = m0;
      chk("e0", 32'(e0), 32'((t > S) && (t <= S + EH)));
      chk("rs0", 32'(lrs0), 32'(inx ? rs : 1'b0));
      chk("rw0", 32'(lrw0), 32'(inx ? rw : 1'b1));
      chk("bus0", 32'(bus0),
          32'((inx && !rw) ? d : m0));
      chk("rdv0", 32'(rdv0),
          32'(rw && (t == S + EH + 1)));
      chk("rdd0", 32'(rdd0), 32'(exp_rd0));
      chk("rdy0", 32'(rdy0), 32'(t == XFER + 1));
    end
  endtask

  // Reference: polls needed, ready offset and timeout
  // offset from the acceptance edge.
  function automatic void model1(
    input  bit rs,
    input  bit rw,
    input  int busy,
    output int polls,
    output int t_rdy,
    output int t_bto
  );
    int need;
    polls = 0;
    t_bto = 0;
    if (!(!rs && rw)) begin
      need = XFER * (busy + 1);
      if (need >= T) begin
        polls = (T + XFER - 1) / XFER;
        t_bto = XFER + 1 + T;
      end else begin
        polls = busy + 1;
      end
    end
    t_rdy = XFER + 1 + XFER * polls;
  endfunction

  task automatic run1(
    input logic       rs,
    input logic       rw,
    input logic [7:0] d,
    input int         busy,
    input string      tag
  );
    int t_rdy = 0, pulses = 0, rdv = 0;
    int t_bto = 0, bad = 0;
    int mp, mt, mb;
    bit ep = 1'b0;
    bit bto_prev;
    bto_prev = bto1;
    busy1 = busy;
    base1 = e_cnt1;
    rs1 = rs; rw1 = rw; d1 = d; v1 = 1'b1;
    wait_rdy(1, {tag, "_wait"});
    @(posedge clk);
    #1;
    v1 = 1'b0;
    for (int t = 1; t <= 600; t++) begin
      @(negedge clk);
      if (e1 && !ep) pulses++;
      ep = e1;
      if (rdv1) rdv++;
      if (bto1 && t_bto == 0) t_bto = t;
      if (lrw1 && (bus1 !== m1)) bad++;
      if (rdy1) begin
        t_rdy = t;
        break;
      end
    end
    model1(rs, rw, busy, mp, mt, mb);
    chk({tag, "_t_rdy"}, t_rdy, mt);
    chk({tag, "_epulses"}, pulses, 1 + mp);
    chk({tag, "_rdv"}, rdv, 32'(rw));
    chk({tag, "_busdrv"}, bad, 0);
    if (!bto_prev) chk({tag, "_t_bto"}, t_bto, mb);
    if (rw) chk({tag, "_rdd"}, 32'(rdd1),
                32'({1'b0, m1lo[6:0]}));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1);
  end

  initial begin
    int rv;
    reset = 1'b1;
    v0 = 0; rs0 = 0; rw0 = 0; d0 = 0; m0 = 8'h41;
    v1 = 0; rs1 = 0; rw1 = 0; d1 = 0; m1lo = 8'h2A;
    busy1 = 0; base1 = 0; exp_rd0 = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst_e", 32'(e0), 0);
    chk("rst_rs", 32'(lrs0), 0);
    chk("rst_rw", 32'(lrw0), 1);
    chk("rst_bus", 32'(bus0), 32'(m0));
    chk("rst_rdy0", 32'(rdy0), 0);
    chk("rst_rdy1", 32'(rdy1), 0);
    chk("rst_rdv", 32'(rdv0), 0);
    chk("rst_rdd", 32'(rdd0), 0);
    chk("rst_bto", 32'(bto1), 0);
    reset = 1'b0;
    #1;
    chk("rdy_pre_edge", 32'(rdy0), 0);
    @(negedge clk);
    chk("rdy_post0", 32'(rdy0), 1);
    chk("rdy_post1", 32'(rdy1), 1);

    // write 0x38, then data read of 0x5A
    run0(1'b0, 1'b0, 8'h38, 1'b0);
    m0 = 8'h5A;
    run0(1'b1, 1'b1, 8'hA5, 1'b0);

    for (int i = 0; i < 6; i++) begin
      m0 = 8'($urandom);
      run0(1'($urandom), 1'($urandom), 8'($urandom), 1'b0);
    end

    // back-to-back writes with cmd_valid held high
    run0(1'b0, 1'b0, 8'h11, 1'b1);
    run0(1'b1, 1'b0, 8'h22, 1'b1);
    run0(1'b0, 1'b0, 8'h33, 1'b0);

    // polling instance
    run1(1'b0, 1'b0, 8'h01, 3, "poll3");
    chk("poll3_bto", 32'(bto1), 0);
    run1(1'b0, 1'b1, 8'h00, 5, "status");
    run1(1'b1, 1'b1, 8'h00, 2, "dread");
    run1(1'b1, 1'b0, 8'h41, 0, "dwrite");
    for (int i = 0; i < 3; i++) begin
      m1lo = 8'($urandom);
      run1(1'($urandom), 1'($urandom), 8'($urandom),
           int'($urandom_range(0, 4)), "rnd1");
    end
    run1(1'b0, 1'b0, 8'h28, 1000, "stuck");
    chk("stuck_bto", 32'(bto1), 1);
    run1(1'b0, 1'b0, 8'h0C, 0, "after");
    chk("after_bto", 32'(bto1), 1);

    // reset in E_HIGH of a write
    m0 = 8'h41;
    rs0 = 1'b0; rw0 = 1'b0; d0 = 8'h3C; v0 = 1'b1;
    wait_rdy(0, "mrst_wait");
    @(posedge clk);
    #1;
    v0 = 1'b0;
    repeat (S + 3) @(negedge clk);
    chk("mrst_pre_e", 32'(e0), 1);
    chk("mrst_pre_bus", 32'(bus0), 32'h3C);
    #2 reset = 1'b1;
    #1;
    chk("mrst_e", 32'(e0), 0);
    chk("mrst_bus", 32'(bus0), 32'(m0));
    chk("mrst_rs", 32'(lrs0), 0);
    chk("mrst_rw", 32'(lrw0), 1);
    chk("mrst_rdy", 32'(rdy0), 0);
    chk("mrst_bto", 32'(bto1), 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("mrst_rdy_up", 32'(rdy0), 1);
    exp_rd0 = 8'h00;

    // reset on the sampling cycle of a read
    m0 = 8'h77;
    rs0 = 1'b1; rw0 = 1'b1; d0 = 8'h00; v0 = 1'b1;
    wait_rdy(0, "rrst_wait");
    @(posedge clk);
    #1;
    v0 = 1'b0;
    repeat (S + EH) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("rrst_e", 32'(e0), 0);
    @(negedge clk);
    reset = 1'b0;
    rv = 0;
    repeat (20) begin
      @(negedge clk);
      if (rdv0) rv++;
    end
    chk("rrst_rdv", rv, 0);
    chk("rrst_rdd", 32'(rdd0), 0);
    chk("rrst_rdy", 32'(rdy0), 1);

    // normal operation resumes
    run0(1'b1, 1'b0, 8'hC3, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
